// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: configurable data width, parity and stop bits,
// internal baud divider and a valid/ready load handshake.
module uart_tx_param #(
    parameter int DATA_BITS = 8,
    parameter int PRESC_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PRESC_W-1:0]   prescaler,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_pin,
    output logic                 busy,
    output logic                 tx_done,
    output logic [2:0]           state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t               state;
    state_t               state_next;

    logic [PRESC_W-1:0]   baud_cnt;
    logic [PRESC_W-1:0]   presc_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [3:0]           bit_idx;
    logic                 stop_idx;
    logic                 two_stop_q;
    logic                 parity_en_q;
    logic                 parity_q;
    logic                 pin_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 accept;
    logic                 bit_end;
    logic                 stop_last;
    logic                 pin_next;

    // Handshake: a word moves when tx_valid and tx_ready are both high at a
    // rising edge. tx_ready is also high during the final cycle of the last
    // stop bit so a waiting word can follow with no idle gap.
    always_comb begin
        state_next = state;
        stop_last  = 1'b0;
        pin_next   = 1'b1;
        bit_end    = (baud_cnt == presc_q - PRESC_W'(1));

        case (state)
            IDLE: begin
                pin_next = 1'b1;
            end
            START: begin
                pin_next = 1'b0;
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                pin_next = shift_q[0];
                if (bit_end && (bit_idx == 4'(DATA_BITS - 1)))
                    state_next = parity_en_q ? PARITY : STOP;
            end
            PARITY: begin
                pin_next = parity_q;
                if (bit_end) state_next = STOP;
            end
            STOP: begin
                pin_next = 1'b1;
                if (bit_end && (stop_idx == two_stop_q)) begin
                    stop_last  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        tx_ready = (state == IDLE) || stop_last;
        accept   = tx_valid && tx_ready;
        if (accept) state_next = START;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_cnt    <= '0;
            presc_q     <= '0;
            shift_q     <= '0;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            two_stop_q  <= 1'b0;
            parity_en_q <= 1'b0;
            parity_q    <= 1'b0;
        end else if (accept) begin
            baud_cnt    <= '0;
            presc_q     <= (prescaler == '0) ? PRESC_W'(1) : prescaler;
            shift_q     <= tx_data;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            two_stop_q  <= two_stop;
            parity_en_q <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
            parity_q    <= (^tx_data) ^ (parity_mode == 2'b10);
        end else if (state != IDLE) begin
            if (bit_end) begin
                baud_cnt <= '0;
                if (state == DATA) begin
                    shift_q <= shift_q >> 1;
                    bit_idx <= bit_idx + 4'd1;
                end
                if (state == STOP) stop_idx <= 1'b1;
            end else begin
                baud_cnt <= baud_cnt + PRESC_W'(1);
            end
        end
    end

    // Line-side outputs trail the state by one clock so the start bit appears
    // one edge after acceptance and tx_pin always comes straight from a flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pin_q  <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            pin_q  <= pin_next;
            busy_q <= (state != IDLE);
            done_q <= stop_last;
        end
    end

    assign tx_pin    = pin_q;
    assign busy      = busy_q;
    assign tx_done   = done_q;
    assign state_dbg = state;

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter. Successor to the fixed 8N1 transmitter: data width, parity mode and stop-bit count are configurable, and the block has an internal baud divider and a valid/ready load handshake. It sits between a byte/word producer (CPU bus or FIFO) and the board tx pin. Frame config and data are captured at acceptance, so upstream may change its inputs while a frame is in flight.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
PRESC_W, 16, width of the prescaler input.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
prescaler  input  PRESC_W  clk cycles per bit; 0 is treated as 1
parity_mode  input  2  00 none, 01 even, 10 odd, 11 none
two_stop  input  1  1 selects 2 stop bits, 0 selects 1 stop bit
tx_data  input  DATA_BITS  word to send, LSB first
tx_valid  input  1  producer has a word
tx_ready  output  1  block can accept a word
tx_pin  output  1  serial line, idle high
busy  output  1  frame in progress
tx_done  output  1  one-cycle pulse at end of the final stop bit

Behaviour:
- Reset (asynchronous, active low; takes effect immediately, mid-frame included):
  - tx_pin=1, tx_ready=1, busy=0, tx_done=0, state IDLE, all counters 0.
  - A partially sent frame is abandoned. No tx_done is generated for it.
- Handshake:
  - A word is accepted on a rising clk edge where tx_valid=1 and tx_ready=1.
  - At that edge the block captures tx_data, parity_mode, two_stop and prescaler (0 becomes 1).
  - tx_ready stays 0 from the accept edge until the edge that ends the last stop bit.
  - tx_valid held low has no effect.
- Latency: tx_pin goes low (start bit) on the edge after the accept edge, i.e. one clk after accept.
- Bit period: every bit lasts exactly P clk cycles, where P is the captured prescaler.
  - The internal baud counter runs 0..P-1.
  - The bit advances when the counter reaches P-1.
  - The counter resets to 0 at accept and on every bit advance.
- State machine (tx_pin value shown per state):
  - IDLE: tx_pin=1. On accept, go to START.
  - START: tx_pin=0 for P cycles, then DATA.
  - DATA: DATA_BITS bits, LSB first; 4-bit bit index. After the last bit, go to PARITY if parity is enabled, otherwise to STOP.
  - PARITY: even mode sends the XOR of the data bits; odd mode sends its inverse. Lasts P cycles, then STOP.
  - STOP: tx_pin=1 for P cycles, or 2P cycles when two_stop is set. At the end: tx_done=1 for one cycle, busy=0, tx_ready=1, then IDLE.
- Back-to-back frames:
  - If tx_valid=1 in the cycle tx_ready rises, the next word is accepted on that edge.
  - Its start bit follows immediately. No extra idle bit is inserted; the minimum gap is 0 bits beyond the stop bits.
- busy is 1 from the edge after accept through the last stop-bit cycle.
- Frame length in clk cycles = P*(1 + DATA_BITS + parity_en + 1 + two_stop).
- Input changes mid-frame (prescaler, parity_mode, two_stop, tx_data) do not affect the current frame.
- tx_pin is driven from a flop: glitch-free and never combinational.

Test Plan:
- Basic frame: reset low 3 cycles, then release; prescaler=4, parity_mode=01, two_stop=0, tx_data=8'hA5, one-cycle tx_valid.
  - tx_pin sequence per 4-cycle bit: 0, 1,0,1,0,0,1,0,1, parity 0, stop 1.
  - Total 44 cycles. tx_done pulses once. tx_ready returns 1 at cycle 44 after accept.
- Odd parity, two stops: tx_data=8'h07, parity_mode=10, two_stop=1, prescaler=2.
  - Parity bit is 0 (three ones, odd already satisfied). Stop high for 4 cycles. Frame is 24 cycles.
- Back-to-back: tx_valid held high with 8'h55 then 8'hAA, prescaler=1, no parity.
  - 20 contiguous bit cycles with no idle between frames. tx_done pulses at cycles 10 and 20.
- Reset mid-frame: assert reset during data bit 3 (asynchronously, between clock edges).
  - tx_pin=1, tx_ready=1 and busy=0 without waiting for a clock edge; no tx_done.
  - The next accepted frame is correct.
- Capture isolation and prescaler=0:
  - Change tx_data, prescaler and parity_mode one cycle after accept: the frame matches the captured values.
  - A frame with prescaler=0 uses a 1-cycle bit period.
- DATA_BITS=9 build: tx_data=9'h1FF, even parity, prescaler=3.
  - Nine 1s, then parity 1. Frame is 36 cycles.
